// File: rtl/fifo_pack_reader.sv
// Pops words from an 8x18 fifo and packs PACK of them into one valid/ready beat.
// Optional macro FLUSH_TIMEOUT_EN flushes a partial beat after TIMEOUT idle cycles.
module fifo_pack_reader #(
   parameter int unsigned DATA_W  = 18,
   parameter int unsigned PACK    = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fifo_empty,
   input  logic [DATA_W-1:0]        fifo_out,
   input  logic                     up_write,
   output logic                     fifo_read,
   output logic [DATA_W*PACK-1:0]   out_data,
   output logic [2:0]               out_count,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned BEAT_W = DATA_W * PACK;
   localparam int unsigned IDX_W  = 3;

   if (PACK < 1 || PACK > 4) begin : g_bad_pack
      $error("fifo_pack_reader: PACK must be in 1..4");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fifo_pack_reader: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_OUT
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic                wr_clash_q;
   logic                fifo_read_q;
   logic                out_valid_q;
   logic [BEAT_W-1:0]   out_data_q;
   logic [2:0]          out_count_q;

`ifdef FLUSH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0]    cnt_q;
`endif

   // Pop sequencing, beat assembly and output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         wr_clash_q  <= 1'b0;
         fifo_read_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
`ifdef FLUSH_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state_q     <= S_ISSUE;
                  fifo_read_q <= 1'b1;
`ifdef FLUSH_TIMEOUT_EN
                  cnt_q       <= '0;
`endif
               end
`ifdef FLUSH_TIMEOUT_EN
               // idx is always below PACK here, so nonzero means a partial beat.
               else if (idx_q != '0) begin
                  if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                     out_count_q <= idx_q;
                     out_valid_q <= 1'b1;
                     state_q     <= S_OUT;
                     idx_q       <= '0;
                     cnt_q       <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`endif
            end
            S_ISSUE: begin
               wr_clash_q  <= up_write;
               fifo_read_q <= 1'b0;
               state_q     <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // A clashing write means the fifo ignored the pop: retry from IDLE.
               if (wr_clash_q) begin
                  state_q <= S_IDLE;
               end else begin
                  out_data_q[idx_q*DATA_W +: DATA_W] <= fifo_out;
`ifdef FLUSH_TIMEOUT_EN
                  cnt_q <= '0;
`endif
                  if (idx_q == IDX_W'(PACK - 1)) begin
                     out_count_q <= 3'(PACK);
                     out_valid_q <= 1'b1;
                     idx_q       <= '0;
                     state_q     <= S_OUT;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
                  out_count_q <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign fifo_read = fifo_read_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Scoreboard bench for fifo_pack_reader with a behavioural fifo model.
module tb_fifo_pack_reader;

   localparam int unsigned DATA_W = 18;
   localparam int unsigned PACK   = 2;
   localparam int unsigned BEAT_W = DATA_W * PACK;

   logic                clk = 1'b0;
   logic                rst;
   logic                fifo_empty;
   logic [DATA_W-1:0]   fifo_out = '0;
   logic                up_write;
   logic                fifo_read;
   logic [BEAT_W-1:0]   out_data;
   logic [2:0]          out_count;
   logic                out_valid;
   logic                out_ready;

   typedef struct packed {
      logic [BEAT_W-1:0] data;
      logic [2:0]        cnt;
   } beat_t;

   beat_t               exp_q[$];
   logic [DATA_W-1:0]   fq[$];
   logic [DATA_W-1:0]   up_word = '0;
   int                  n_loaded = 0;
   int                  n_popped = 0;
   int                  n_up = 0;
   int                  n_cmp = 0;
   int                  n_err = 0;
   int                  n_pulse = 0;
   int                  valid_seen = 0;
   bit                  hold_prev = 1'b0;
   logic [BEAT_W-1:0]   hold_data = '0;
   logic [2:0]          hold_cnt = '0;

   always #5 clk = ~clk;

   fifo_pack_reader #(.DATA_W(DATA_W), .PACK(PACK), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_out   (fifo_out),
      .up_write   (up_write),
      .fifo_read  (fifo_read),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   // Fifo model: registered read data, write wins over read.
   assign fifo_empty = ((n_loaded + n_up) == n_popped);

   always @(posedge clk) begin
      if (fifo_read && !up_write && fq.size() > 0) begin
         fifo_out <= fq[0];
         void'(fq.pop_front());
         n_popped <= n_popped + 1;
      end
      if (up_write) begin
         fq.push_back(up_word);
         n_up <= n_up + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input logic [DATA_W-1:0] w);
      fq.push_back(w);
      n_loaded++;
   endtask

   task automatic expect_beat(input logic [BEAT_W-1:0] d, input logic [2:0] c);
      beat_t b;
      b.data = d;
      b.cnt  = c;
      exp_q.push_back(b);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: handshake scoreboard, hold stability and no pops during OUT.
   always @(negedge clk) begin
      beat_t e;
      #1;
      if (!rst) begin
         if (fifo_read) n_pulse++;
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(hold_data));
            check("hold_count", 64'(out_count), 64'(hold_cnt));
         end
         if (out_valid) begin
            valid_seen++;
            check("no_pop_in_out", 64'(fifo_read), 64'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got %h/%0d expected none", out_data, out_count);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 64'(out_data), 64'(e.data));
               check("beat_count", 64'(out_count), 64'(e.cnt));
            end
         end
         hold_prev = out_valid && !out_ready;
         hold_data = out_data;
         hold_cnt  = out_count;
      end
   end

   initial begin
      int k;
      rst       = 1'b1;
      up_write  = 1'b0;
      out_ready = 1'b1;

      // Reset with a non-empty fifo, then basic pack.
      @(negedge clk);
      load(18'h00011);
      load(18'h3FFFF);
      expect_beat(36'hFFFFC0011, 3'd2);
      @(negedge clk);
      @(negedge clk);
      check("rst_fifo_read", 64'(fifo_read), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("first_pop", 64'(fifo_read), 64'd1);
      wait_drain(60);
      check("basic_pops", 64'(n_pulse), 64'd2);
      check("basic_valid_cycles", 64'(valid_seen), 64'd1);

      // Write clash during the first ISSUE forces one retried pop.
      n_pulse = 0;
      up_word = 18'h15555;
      @(negedge clk);
      load(18'h12345);
      load(18'h00F0F);
      load(18'h2AAAA);
      expect_beat(36'h03C3D2345, 3'd2);
      expect_beat(36'h55556AAAA, 3'd2);
      @(negedge clk);
      check("clash_issue", 64'(fifo_read), 64'd1);
      up_write = 1'b1;
      @(negedge clk);
      up_write = 1'b0;
      wait_drain(80);
      check("clash_pops", 64'(n_pulse), 64'd5);

      // Backpressure: beat held, no pops while OUT.
      n_pulse   = 0;
      out_ready = 1'b0;
      load(18'h00001);
      load(18'h00002);
      expect_beat(36'h000080001, 3'd2);
      expect_beat(36'h000100003, 3'd2);
      k = 0;
      while (!out_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      check("bp_valid_seen", 64'(out_valid), 64'd1);
      load(18'h00003);
      load(18'h00004);
      repeat (5) @(negedge clk);
      check("bp_pops_held", 64'(n_pulse), 64'd2);
      out_ready = 1'b1;
      wait_drain(60);
      check("bp_pops_resumed", 64'(n_pulse), 64'd4);

`ifndef FLUSH_TIMEOUT_EN
      // Empty stall: a single word never produces a beat.
      n_pulse    = 0;
      valid_seen = 0;
      load(18'h00ABC);
      repeat (40) @(negedge clk);
      check("stall_pops", 64'(n_pulse), 64'd1);
      check("stall_valid_cycles", 64'(valid_seen), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd0);
      load(18'h00DEF);
      expect_beat(36'h037BC0ABC, 3'd2);
      wait_drain(40);
`else
      // Partial beat flushed 16 cycles after its capture.
      load(18'h00ABC);
      expect_beat(36'h000000ABC, 3'd1);
      k = 0;
      while (!out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("flush_latency", 64'(k), 64'd19);
      wait_drain(20);
`endif

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
- Downstream consumer of the 8-deep x 18-bit fifo.
- Pops words through the fifo's read strobe and captures the registered fifo_out one cycle later.
- Packs PACK consecutive words into one wide beat and presents it on a valid/ready interface to the next processing stage.
- Retries a pop when the fifo ignored it because an upstream write took priority in the same cycle.

Parameters:
- DATA_W, 18: width of one fifo word.
- PACK, 2: words per output beat (legal 1..4).
- TIMEOUT, 16: idle cycles before a partial beat is flushed (used only with FLUSH_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- fifo_empty  input  1  fifo empty flag
- fifo_out  input  DATA_W  fifo registered read data
- up_write  input  1  upstream write strobe into the same fifo; write wins over read
- fifo_read  output  1  pop request to fifo, registered
- out_data  output  DATA_W*PACK  packed beat; word 0 in LSBs
- out_count  output  3  number of valid words in out_data (1..PACK)
- out_valid  output  1  beat available
- out_ready  input  1  downstream accepts beat

Behaviour:
- Reset, sampled at the clk edge when rst=1:
  - State returns to IDLE; slot index is cleared; timeout counter is cleared.
  - fifo_read=0, out_valid=0, out_data=0, out_count=0.
  - Reset mid-operation discards any partial beat and any outstanding pop.
- IDLE:
  - fifo_empty=0 → ISSUE; fifo_read=1 is registered for the next cycle.
  - Otherwise stay in IDLE.
- ISSUE (fifo_read=1 for exactly one cycle):
  - Latch up_write into wr_clash.
  - Always → CAPTURE; fifo_read returns to 0.
- CAPTURE (fifo_out now holds popped word):
  - If wr_clash=1, the pop was ignored by the fifo: no capture; → IDLE, which re-checks fifo_empty and retries.
  - Else write fifo_out into slot idx of the pack register; idx increments.
  - If idx was PACK-1: out_count=PACK, out_valid=1, → OUT, idx=0.
  - Otherwise → IDLE.
- OUT:
  - out_data, out_count and out_valid are held stable while out_valid=1 and out_ready=0.
  - Handshake completes on a cycle with out_valid=1 and out_ready=1; then out_valid=0 and → IDLE.
  - Pack register is cleared to 0 on completion.
  - No pops are issued while in OUT.
- Read latency: at most one pop every 3 cycles (IDLE→ISSUE→CAPTURE). First word captured at the edge 3 cycles after fifo_empty falls in IDLE.
- Ordering: words appear in out_data in pop order; unused slots are 0.
- fifo_read is never asserted while fifo_empty was 1 in the preceding IDLE cycle.
- out_ready is ignored outside OUT.

Optional Feature:
- FLUSH_TIMEOUT_EN defined:
  - In IDLE with 0<idx<PACK and fifo_empty=1, a counter increments each cycle.
  - The counter clears on any capture or on fifo_empty=0.
  - When the counter reaches TIMEOUT-1: out_count=idx, out_valid=1, → OUT, idx=0, counter=0.
- FLUSH_TIMEOUT_EN undefined:
  - No counter; partial beats wait indefinitely.
  - out_count is always PACK when out_valid=1.

Test Plan:
- Reset: rst=1 for 2 cycles with fifo_empty=0 → fifo_read=0, out_valid=0, out_data=0, out_count=0; first fifo_read=1 appears 1 cycle after rst falls.
- Basic pack (PACK=2): fifo holds 0x00011, 0x3FFFF; out_ready=1 → single beat out_data=0xFFFFC0011, out_count=2, valid 1 cycle; exactly 2 fifo_read pulses.
- Write clash: up_write=1 during the first ISSUE → no capture; a second fifo_read pulse is issued; beat still equals the first two words in fifo order.
- Backpressure: out_ready=0 for 5 cycles in OUT → out_data/out_valid stable, no fifo_read pulses; out_ready=1 → beat accepted, pops resume.
- Empty stall: fifo_empty=1 after one word → fifo_read stays 0, out_valid stays 0 indefinitely (macro off).
- FLUSH_TIMEOUT_EN, TIMEOUT=16: one word 0x00ABC then empty → out_valid=1 with out_count=1, out_data=0x00000ABC, 16 cycles after the capture.
